// File: rtl/cvp14_pkg.sv
// Shared widths, opcode encodings and FSM states for the CVP14 vector core.
package cvp14_pkg;

  localparam int WORD_W = 16;
  localparam int VLEN   = 16;
  localparam int NREG   = 8;
  localparam int RIDX_W = $clog2(NREG);
  localparam int EIDX_W = $clog2(VLEN);

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_VADD = 4'h0;
  localparam opcode_t OP_VLD  = 4'h1;
  localparam opcode_t OP_VST  = 4'h2;
  localparam opcode_t OP_SLL  = 4'h3;
  localparam opcode_t OP_SLH  = 4'h4;
  localparam opcode_t OP_SADD = 4'h5;
  localparam opcode_t OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALT
  } state_t;

  // Signed overflow of a two's-complement add: operands agree in sign, sum does not.
  function automatic logic add_ovf(input logic [WORD_W-1:0] a,
                                   input logic [WORD_W-1:0] b,
                                   input logic [WORD_W-1:0] sum);
    return (a[WORD_W-1] == b[WORD_W-1]) && (sum[WORD_W-1] != a[WORD_W-1]);
  endfunction

endpackage

// File: rtl/cvp14_regfile.sv
// Scalar (S0..S7) and vector (V0..V7 x 16 elements) register files.
// Three combinational read ports indexed by d/s/t; all writes target register d.
module cvp14_regfile
  import cvp14_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [RIDX_W-1:0] i_rd_idx,
  input  logic [RIDX_W-1:0] i_rs_idx,
  input  logic [RIDX_W-1:0] i_rt_idx,
  input  logic [EIDX_W-1:0] i_relem,
  output logic [WORD_W-1:0] o_s_d,
  output logic [WORD_W-1:0] o_s_s,
  output logic [WORD_W-1:0] o_s_t,
  output logic [WORD_W-1:0] o_v_d,
  output logic [WORD_W-1:0] o_v_s,
  output logic [WORD_W-1:0] o_v_t,
  input  logic              i_s_we,
  input  logic [WORD_W-1:0] i_s_wdata,
  input  logic              i_v_we,
  input  logic [EIDX_W-1:0] i_v_welem,
  input  logic [WORD_W-1:0] i_v_wdata
);

  logic [WORD_W-1:0] r_sreg [NREG];
  logic [WORD_W-1:0] r_vreg [NREG][VLEN];

  // NOTE: these arrays live in flops, not SRAM, because every register must read zero
  // straight out of reset; a RAM macro could not be cleared asynchronously.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        r_sreg[r] <= '0;
        for (int e = 0; e < VLEN; e++) r_vreg[r][e] <= '0;
      end
    end else begin
      if (i_s_we) r_sreg[i_rd_idx] <= i_s_wdata;
      if (i_v_we) r_vreg[i_rd_idx][i_v_welem] <= i_v_wdata;
    end
  end

  assign o_s_d = r_sreg[i_rd_idx];
  assign o_s_s = r_sreg[i_rs_idx];
  assign o_s_t = r_sreg[i_rt_idx];
  assign o_v_d = r_vreg[i_rd_idx][i_relem];
  assign o_v_s = r_vreg[i_rs_idx][i_relem];
  assign o_v_t = r_vreg[i_rt_idx][i_relem];

endmodule

// File: rtl/cvp14_core.sv
// CVP14 vector core: FETCH/DECODE/EXEC/HALT controller and datapath around the register file.
// Memory strobes are decoded from the current state so RD rises in the first cycle after reset.
module cvp14_core
  import cvp14_pkg::*;
(
  input  logic              Clk1,
  input  logic              Reset,
  input  logic              Clk2,
  output logic [WORD_W-1:0] Addr,
  output logic              RD,
  output logic              WR,
  output logic [WORD_W-1:0] DataOut,
  input  logic [WORD_W-1:0] DataIn,
  output logic              V
);

  localparam logic [EIDX_W:0] CNT_LAST = (EIDX_W + 1)'(VLEN - 1);

  state_t            r_state, w_state_nxt;
  logic [WORD_W-1:0] r_pc, r_ir, r_addr_last;
  logic [EIDX_W:0]   r_cnt;
  logic              r_ovf_acc, r_v;

  logic [3:0]        w_op;
  logic [RIDX_W-1:0] w_d, w_s, w_t;
  logic [7:0]        w_imm;
  logic [EIDX_W-1:0] w_elem;
  logic [WORD_W-1:0] w_sd, w_ss, w_st, w_vd, w_vs, w_vt;
  logic [WORD_W-1:0] w_sum, w_mem_addr, w_addr, w_s_wdata, w_v_wdata;
  logic [EIDX_W-1:0] w_v_welem;
  logic              w_lane_ovf, w_rd, w_wr, w_s_we, w_v_we, w_done;
  logic              w_unused;

  assign w_unused = Clk2;

  assign w_op       = r_ir[15:12];
  assign w_d        = r_ir[11:9];
  assign w_s        = r_ir[8:6];
  assign w_t        = r_ir[5:3];
  assign w_imm      = r_ir[7:0];
  assign w_elem     = r_cnt[EIDX_W-1:0];
  assign w_sum      = w_vs + w_vt;
  assign w_lane_ovf = add_ovf(w_vs, w_vt, w_sum);
  assign w_mem_addr = w_ss + WORD_W'(w_elem);

  cvp14_regfile u_regfile (
    .i_clk     (Clk1),
    .i_rst_n   (Reset),
    .i_rd_idx  (w_d),
    .i_rs_idx  (w_s),
    .i_rt_idx  (w_t),
    .i_relem   (w_elem),
    .o_s_d     (w_sd),
    .o_s_s     (w_ss),
    .o_s_t     (w_st),
    .o_v_d     (w_vd),
    .o_v_s     (w_vs),
    .o_v_t     (w_vt),
    .i_s_we    (w_s_we),
    .i_s_wdata (w_s_wdata),
    .i_v_we    (w_v_we),
    .i_v_welem (w_v_welem),
    .i_v_wdata (w_v_wdata)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_rd        = 1'b0;
    w_wr        = 1'b0;
    w_addr      = r_addr_last;
    w_s_we      = 1'b0;
    w_s_wdata   = w_sd;
    w_v_we      = 1'b0;
    w_v_welem   = w_elem;
    w_v_wdata   = w_sum;
    w_done      = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_rd        = 1'b1;
        w_addr      = r_pc;
        w_state_nxt = ST_DECODE;
      end
      ST_DECODE: w_state_nxt = (DataIn[15:12] == OP_HALT) ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        case (w_op)
          OP_VADD: begin
            w_v_we = 1'b1;
            w_done = (r_cnt == CNT_LAST);
          end
          OP_VLD: begin
            // Issue 16 reads, then capture each word one cycle behind its request.
            if (!r_cnt[EIDX_W]) begin
              w_rd   = 1'b1;
              w_addr = w_mem_addr;
            end
            if (r_cnt != '0) begin
              w_v_we    = 1'b1;
              w_v_welem = w_elem - 1'b1;
              w_v_wdata = DataIn;
            end
            w_done = r_cnt[EIDX_W];
          end
          OP_VST: begin
            w_wr   = 1'b1;
            w_addr = w_mem_addr;
            w_done = (r_cnt == CNT_LAST);
          end
          OP_SLL: begin
            w_s_we    = 1'b1;
            w_s_wdata = {w_sd[15:8], w_imm};
            w_done    = 1'b1;
          end
          OP_SLH: begin
            w_s_we    = 1'b1;
            w_s_wdata = {w_imm, w_sd[7:0]};
            w_done    = 1'b1;
          end
          OP_SADD: begin
            w_s_we    = 1'b1;
            w_s_wdata = w_ss + w_st;
            w_done    = 1'b1;
          end
          default: w_done = 1'b1;
        endcase
        if (w_done) w_state_nxt = ST_FETCH;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk1 or negedge Reset) begin
    if (!Reset) begin
      r_state     <= ST_FETCH;
      r_pc        <= '0;
      r_ir        <= '0;
      r_cnt       <= '0;
      r_addr_last <= '0;
      r_ovf_acc   <= 1'b0;
      r_v         <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr_last <= w_addr;
      if (r_state == ST_DECODE) begin
        r_ir      <= DataIn;
        r_pc      <= r_pc + 16'd1;
        r_cnt     <= '0;
        r_ovf_acc <= 1'b0;
      end else if (r_state == ST_EXEC) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_op == OP_VADD) begin
          r_ovf_acc <= r_ovf_acc | w_lane_ovf;
          if (w_done) r_v <= r_ovf_acc | w_lane_ovf;
        end
      end
    end
  end

  // FETCH holds RD high while in reset state, so gate it with the reset itself.
  assign RD      = Reset & w_rd;
  assign WR      = w_wr;
  assign Addr    = w_addr;
  assign DataOut = w_wr ? w_vd : '0;
  assign V       = r_v;

endmodule

// File: tb/tb_cvp14_core.sv
// Directed bench for cvp14_core: program images in a 64K x 16 memory model,
// scoreboard queues for expected write beats and vector-load addresses.
module tb_cvp14_core;
  import cvp14_pkg::*;

  logic        Clk1 = 1'b0;
  logic        Clk2 = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] Addr, DataOut, DataIn;
  logic        RD, WR, V;

  cvp14_core dut (
    .Clk1    (Clk1),
    .Reset   (Reset),
    .Clk2    (Clk2),
    .Addr    (Addr),
    .RD      (RD),
    .WR      (WR),
    .DataOut (DataOut),
    .DataIn  (DataIn),
    .V       (V)
  );

  always #5 Clk1 = ~Clk1;
  always #7 Clk2 = ~Clk2;

  logic [15:0] mem [0:65535];

  always @(posedge Clk1) begin
    if (RD) DataIn <= mem[Addr];
    if (WR) mem[Addr] = DataOut;
  end

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        v;
  } wr_exp_t;

  wr_exp_t     wr_q[$];
  logic [15:0] rd_q[$];
  wr_exp_t     mon_e;
  logic [15:0] mon_a;
  int          wr_run, last_run;
  int          n_pass = 0, n_total = 0;
  logic [15:0] exp_v6 [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] i_rrr(input logic [3:0] op, input logic [2:0] d,
                                        input logic [2:0] s, input logic [2:0] t);
    return {op, d, s, t, 3'b000};
  endfunction

  function automatic logic [15:0] i_imm(input logic [3:0] op, input logic [2:0] d,
                                        input logic [7:0] imm);
    return {op, d, 1'b0, imm};
  endfunction

  task automatic push_vld(input logic [15:0] base);
    for (int k = 0; k < 16; k++) rd_q.push_back(base + 16'(k));
  endtask

  task automatic push_wr(input logic [15:0] base, input logic [15:0] data, input logic step, input logic v);
    wr_exp_t e;
    for (int k = 0; k < 16; k++) begin
      e.addr = base + 16'(k);
      e.data = step ? data * 16'(k) : data;
      e.v    = v;
      wr_q.push_back(e);
    end
  endtask

  always @(negedge Clk1) begin
    if (Reset) begin
      if (WR) begin
        check("wr_expected", 32'(wr_q.size() != 0), 1);
        if (wr_q.size() != 0) begin
          mon_e = wr_q.pop_front();
          check("wr_addr", Addr, mon_e.addr);
          check("wr_data", DataOut, mon_e.data);
          check("wr_vflag", V, mon_e.v);
        end
        check("rd_wr_exclusive", RD, 0);
        wr_run++;
      end else if (wr_run != 0) begin
        last_run = wr_run;
        wr_run   = 0;
      end
      if (RD && dut.r_state == ST_EXEC) begin
        check("rd_expected", 32'(rd_q.size() != 0), 1);
        if (rd_q.size() != 0) begin
          mon_a = rd_q.pop_front();
          check("vld_addr", Addr, mon_a);
        end
      end
    end
  end

  task automatic enter_reset();
    @(negedge Clk1);
    Reset = 1'b0;
    wr_q.delete();
    rd_q.delete();
    wr_run   = 0;
    last_run = 0;
    #1;
    check("rst_addr", Addr, 0);
    check("rst_rd", RD, 0);
    check("rst_wr", WR, 0);
    check("rst_v", V, 0);
    for (int a = 0; a < 65536; a++) mem[a] = '0;
  endtask

  task automatic release_reset();
    @(negedge Clk1);
    Reset = 1'b1;
    #1;
    check("post_rst_rd", RD, 1);
    check("post_rst_addr", Addr, 0);
  endtask

  task automatic wait_halt(input int max, input string tag);
    int n = 0;
    while (dut.r_state != ST_HALT && n < max) begin
      @(negedge Clk1);
      n++;
    end
    check({tag, "_halt_reached"}, 32'(dut.r_state == ST_HALT), 1);
    repeat (4) @(negedge Clk1);
    check({tag, "_halt_rd"}, RD, 0);
    check({tag, "_halt_wr"}, WR, 0);
    check({tag, "_halt_dataout"}, DataOut, 0);
    check({tag, "_wr_q_empty"}, wr_q.size(), 0);
    check({tag, "_rd_q_empty"}, rd_q.size(), 0);
  endtask

  initial begin
    Reset = 1'b0;
    repeat (2) @(negedge Clk1);

    // Program A: build S0 = 0x1234 from two byte loads, then halt.
    enter_reset();
    mem[0] = i_imm(OP_SLL, 3'd0, 8'h34);
    mem[1] = i_imm(OP_SLH, 3'd0, 8'h12);
    mem[2] = {OP_HALT, 12'h000};
    release_reset();
    wait_halt(100, "A");
    check("A_s0", dut.u_regfile.r_sreg[0], 16'h1234);
    check("A_pc", dut.r_pc, 16'd3);
    check("A_addr_hold", Addr, 16'h0002);

    // Program B: VLD V1 from 0x0100, V0 = V1 + V1, VST V0 to 0x0200.
    enter_reset();
    for (int k = 0; k < 16; k++) mem[16'h0100 + k] = 16'(k);
    mem[0] = i_imm(OP_SLH, 3'd1, 8'h01);
    mem[1] = i_rrr(OP_VLD, 3'd1, 3'd1, 3'd0);
    mem[2] = i_rrr(OP_VADD, 3'd0, 3'd1, 3'd1);
    mem[3] = i_imm(OP_SLL, 3'd2, 8'h00);
    mem[4] = i_imm(OP_SLH, 3'd2, 8'h02);
    mem[5] = i_rrr(OP_VST, 3'd0, 3'd2, 3'd0);
    mem[6] = {OP_HALT, 12'h000};
    push_vld(16'h0100);
    push_wr(16'h0200, 16'd2, 1'b1, 1'b0);
    release_reset();
    wait_halt(400, "B");
    for (int k = 0; k < 16; k++) begin
      check($sformatf("B_v1_%0d", k), dut.u_regfile.r_vreg[1][k], 16'(k));
      check($sformatf("B_v0_%0d", k), dut.u_regfile.r_vreg[0][k], 16'(2 * k));
      check($sformatf("B_mem_%0d", k), mem[16'h0200 + k], 16'(2 * k));
    end
    check("B_vflag", V, 0);
    check("B_wr_run", last_run, 16);

    // Program C: overflowing VADD sets V (seen on the VST beats), in-place VADD clears it.
    enter_reset();
    for (int k = 0; k < 16; k++) begin
      mem[16'h0300 + k] = 16'h7FFF;
      mem[16'h0310 + k] = 16'h0001;
    end
    mem[0] = i_imm(OP_SLH, 3'd1, 8'h03);
    mem[1] = i_imm(OP_SLL, 3'd2, 8'h10);
    mem[2] = i_imm(OP_SLH, 3'd2, 8'h03);
    mem[3] = i_imm(OP_SLH, 3'd3, 8'h04);
    mem[4] = i_rrr(OP_VLD, 3'd2, 3'd1, 3'd0);
    mem[5] = i_rrr(OP_VLD, 3'd3, 3'd2, 3'd0);
    mem[6] = i_rrr(OP_VADD, 3'd4, 3'd2, 3'd3);
    mem[7] = i_rrr(OP_VST, 3'd4, 3'd3, 3'd0);
    mem[8] = i_rrr(OP_VADD, 3'd3, 3'd3, 3'd3);
    mem[9] = {OP_HALT, 12'h000};
    push_vld(16'h0300);
    push_vld(16'h0310);
    push_wr(16'h0400, 16'h8000, 1'b0, 1'b1);
    release_reset();
    wait_halt(600, "C");
    check("C_v4_0", dut.u_regfile.r_vreg[4][0], 16'h8000);
    check("C_v3_0", dut.u_regfile.r_vreg[3][0], 16'h0002);
    check("C_v3_15", dut.u_regfile.r_vreg[3][15], 16'h0002);
    check("C_vflag_cleared", V, 0);

    // Program D: SADD wrap, a NOP, and a VLD whose addresses wrap past 0xFFFF into the program.
    enter_reset();
    for (int k = 0; k < 8; k++) mem[16'hFFF8 + k] = 16'hA000 + 16'(k);
    mem[0] = i_imm(OP_SLL, 3'd1, 8'hFF);
    mem[1] = i_imm(OP_SLH, 3'd1, 8'hFF);
    mem[2] = i_imm(OP_SLL, 3'd2, 8'h02);
    mem[3] = i_rrr(OP_SADD, 3'd3, 3'd1, 3'd2);
    mem[4] = 16'h6FFF;
    mem[5] = i_imm(OP_SLL, 3'd4, 8'hF8);
    mem[6] = i_imm(OP_SLH, 3'd4, 8'hFF);
    mem[7] = i_rrr(OP_VLD, 3'd6, 3'd4, 3'd0);
    mem[8] = {OP_HALT, 12'h000};
    for (int k = 0; k < 16; k++) begin
      logic [15:0] a;
      a = 16'hFFF8 + 16'(k);
      exp_v6[k] = mem[a];
    end
    push_vld(16'hFFF8);
    release_reset();
    wait_halt(300, "D");
    check("D_sadd", dut.u_regfile.r_sreg[3], 16'h0001);
    check("D_s4", dut.u_regfile.r_sreg[4], 16'hFFF8);
    check("D_pc", dut.r_pc, 16'd9);
    for (int k = 0; k < 16; k++)
      check($sformatf("D_v6_%0d", k), dut.u_regfile.r_vreg[6][k], exp_v6[k]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cvp14_core.md
CVP14_CORE -- requirements
Module: cvp14_core

Interface
REQ-001 Clk1 input 1: single system clock; all state changes on its rising edge.
REQ-002 Reset input 1: asynchronous, active-low reset.
REQ-003 Clk2 input 1: accepted but unused; no logic depends on it.
REQ-004 Addr output 16: memory word address.
REQ-005 RD output 1: memory read strobe.
REQ-006 WR output 1: memory write strobe.
REQ-007 DataOut output 16: write data to memory.
REQ-008 DataIn input 16: read data from memory, valid in the cycle after RD with Addr was sampled.
REQ-009 V output 1: overflow flag of the last VADD.

Function
REQ-010 State: PC (16b), 8 scalar regs S0..S7 (16b), 8 vector regs V0..V7 (16 elements x 16b), element counter i (4b), instruction reg.
REQ-011 Instruction word: op=[15:12], d=[11:9], s=[8:6], t=[5:3], imm8=[7:0].
REQ-012 FSM states: FETCH, DECODE, EXEC, HALT.
REQ-013 FETCH: Addr=PC, RD=1 for one cycle -> DECODE.
REQ-014 DECODE: latch DataIn into instruction reg, PC<=PC+1 (mod 2^16), i<=0 -> EXEC, or -> HALT if op=1111.
REQ-015 op 0000 VADD: Vd[i]=Vs[i]+Vt[i] mod 2^16, one element per cycle, 16 cycles; V<=1 if any lane has signed overflow, else 0.
REQ-016 op 0001 VLD: Vd[i]=mem[S[s]+i]; issue RD, Addr=S[s]+i for i=0..15 on consecutive cycles, capture each DataIn one cycle later; 17 EXEC cycles.
REQ-017 op 0010 VST: mem[S[s]+i]=Vd[i]; WR=1, Addr=S[s]+i, DataOut=Vd[i] for i=0..15; 16 cycles.
REQ-018 op 0011 SLL: Sd[7:0]=imm8, Sd[15:8] unchanged; 1 cycle.
REQ-019 op 0100 SLH: Sd[15:8]=imm8, Sd[7:0] unchanged; 1 cycle.
REQ-020 op 0101 SADD: Sd=Ss+St mod 2^16; 1 cycle.
REQ-021 Other ops 0110..1110: NOP, 1 EXEC cycle.
REQ-022 EXEC returns to FETCH after its last cycle.
REQ-023 Address arithmetic S[s]+i wraps mod 2^16.
REQ-024 VADD with d equal to s or t: each element reads old value before writing that element.
REQ-025 RD and WR never asserted together; both 0 outside FETCH, VLD and VST cycles.
REQ-026 DataOut=0 when WR=0.
REQ-027 HALT: RD=WR=0, Addr holds, no register changes until reset.
REQ-028 V changes only on VADD completion or reset.

Reset
REQ-029 Reset low forces state FETCH, PC=0, i=0, Addr=0, RD=0, WR=0, DataOut=0, V=0, S0..S7=0, V0..V7=0, regardless of Clk1.
REQ-030 Reset asserted mid-VLD/VST aborts the operation; partial memory writes already done stay.
REQ-031 First cycle after reset release: RD=1, Addr=0.

Structure
REQ-032 Shared package holds the opcode constants, FSM state enum, and widths (word 16, vector length 16, register count 8).
REQ-033 A single sub-module cvp14_regfile holds the scalar and vector register files; the FSM/datapath lives in cvp14_core.
REQ-034 Memory is external; the bench supplies a 64K x 16 one-cycle-latency memory model preloaded with the program.

Verification
REQ-035 Reset low then release -> Addr=0, RD=0, WR=0, V=0 during reset; next cycle RD=1, Addr=0.
REQ-036 Program SLL S0,0x34; SLH S0,0x12; HALT -> S0=0x1234, PC=3, RD/WR stay 0 after halt.
REQ-037 mem[0x0100+k]=k, S1=0x0100, VLD V1,[S1]; VADD V0,V1,V1 -> V0[k]=2k for k=0..15, V=0.
REQ-038 VST V0,[S2] with S2=0x0200 -> WR high 16 consecutive cycles, Addr 0x0200..0x020F, mem[0x0200+k]=2k.
REQ-039 VADD lanes 0x7FFF+0x0001 -> element 0x8000, V=1; following VADD 0x0001+0x0001 in all lanes -> V=0.
REQ-040 SADD 0xFFFF+0x0002 -> 0x0001; VLD base 0xFFF8 -> Addr sequence 0xFFF8..0xFFFF, 0x0000..0x0007.
